// File: rtl/exec_unit_mc_if.sv
// rtl/exec_unit_mc_if.sv - request/response bundle between exec_unit_mc and its client
interface exec_unit_mc_if #(parameter int WIDTH = 32);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             set_flags;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result_lo;
    logic [WIDTH-1:0] result_hi;
    logic [3:0]       flags;
    logic             busy;

    modport master (
        output in_valid, op, a, b, set_flags, out_ready,
        input  in_ready, out_valid, result_lo, result_hi, flags, busy
    );

    modport slave (
        input  in_valid, op, a, b, set_flags, out_ready,
        output in_ready, out_valid, result_lo, result_hi, flags, busy
    );
endinterface

// File: rtl/exec_unit_mc.sv
// rtl/exec_unit_mc.sv - multi-cycle ALU/MUL unit with NZCV flags; EXEC_UNIT_MUL_LONG_EN enables the 2*WIDTH product
module exec_unit_mc #(
    parameter int WIDTH = 32
) (
    input  logic           clk,
    input  logic           reset,
    exec_unit_mc_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_ORR = 3'b011;
    localparam logic [2:0] OP_MUL = 3'b100;
    localparam logic [2:0] OP_MOV = 3'b101;
    localparam int         CW     = $clog2(WIDTH);

    state_t           state_q, state_d;
    logic             in_ready, busy, out_valid, accept, mul_last;
    logic [CW-1:0]    cnt_q;
    logic             sf_q;
    logic [WIDTH-1:0] mcand_q, mplier_q, acc_q;
    logic [WIDTH-1:0] mcand_d, mplier_d, acc_d, addend;
    logic [WIDTH-1:0] prod_lo, prod_hi;
    logic             mul_n, mul_z;
    logic [WIDTH-1:0] res_lo_q, res_hi_q;
    logic [3:0]       flags_q;
    logic [WIDTH:0]   add_sum, sub_dif;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c, alu_v, alu_flag_en;
`ifdef EXEC_UNIT_MUL_LONG_EN
    logic [WIDTH:0]   step_sum;
`endif

    assign accept   = bus.in_valid & in_ready;
    assign mul_last = (cnt_q == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (accept) state_d = (bus.op == OP_MUL) ? S_MUL : S_DONE;
            S_MUL:  if (mul_last) state_d = S_DONE;
            S_DONE: if (bus.out_ready) begin
                if (accept) state_d = (bus.op == OP_MUL) ? S_MUL : S_DONE;
                else        state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        busy      = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            S_IDLE: in_ready = 1'b1;
            S_MUL:  busy = 1'b1;
            S_DONE: begin
                out_valid = 1'b1;
                in_ready  = bus.out_ready;
            end
            default: ;
        endcase
    end

    // Single-cycle ops are computed straight from the accepted operands.
    always_comb begin
        add_sum     = {1'b0, bus.a} + {1'b0, bus.b};
        sub_dif     = {1'b0, bus.a} + {1'b0, ~bus.b} + (WIDTH + 1)'(1);
        alu_res     = '0;
        alu_c       = 1'b0;
        alu_v       = 1'b0;
        alu_flag_en = bus.set_flags;
        unique case (bus.op)
            OP_ADD: begin
                alu_res = add_sum[WIDTH-1:0];
                alu_c   = add_sum[WIDTH];
                alu_v   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (add_sum[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = sub_dif[WIDTH-1:0];
                alu_c   = sub_dif[WIDTH];
                alu_v   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (sub_dif[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_AND:  alu_res = bus.a & bus.b;
            OP_ORR:  alu_res = bus.a | bus.b;
            OP_MOV:  alu_res = bus.b;
            default: alu_flag_en = 1'b0;
        endcase
    end

    // One shift-add step; the long form shifts the product right through mplier_q.
    always_comb begin
        addend = mplier_q[0] ? mcand_q : '0;
`ifdef EXEC_UNIT_MUL_LONG_EN
        step_sum = {1'b0, acc_q} + {1'b0, addend};
        acc_d    = step_sum[WIDTH:1];
        mplier_d = {step_sum[0], mplier_q[WIDTH-1:1]};
        mcand_d  = mcand_q;
        prod_lo  = mplier_d;
        prod_hi  = acc_d;
        mul_n    = acc_d[WIDTH-1];
        mul_z    = (acc_d == '0) && (mplier_d == '0);
`else
        acc_d    = acc_q + addend;
        mplier_d = mplier_q >> 1;
        mcand_d  = mcand_q << 1;
        prod_lo  = acc_d;
        prod_hi  = '0;
        mul_n    = acc_d[WIDTH-1];
        mul_z    = (acc_d == '0);
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q    <= '0;
            sf_q     <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            res_lo_q <= '0;
            res_hi_q <= '0;
            flags_q  <= 4'b0000;
        end else if (accept) begin
            if (bus.op == OP_MUL) begin
                mcand_q  <= bus.a;
                mplier_q <= bus.b;
                acc_q    <= '0;
                cnt_q    <= '0;
                sf_q     <= bus.set_flags;
            end else begin
                res_lo_q <= alu_res;
                res_hi_q <= '0;
                if (alu_flag_en)
                    flags_q <= {alu_res[WIDTH-1], (alu_res == '0), alu_c, alu_v};
            end
        end else if (state_q == S_MUL) begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= mul_last ? '0 : cnt_q + CW'(1);
            if (mul_last) begin
                res_lo_q <= prod_lo;
                res_hi_q <= prod_hi;
                if (sf_q) flags_q <= {mul_n, mul_z, flags_q[1:0]};
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.busy      = busy;
    assign bus.out_valid = out_valid;
    assign bus.result_lo = res_lo_q;
    assign bus.flags     = flags_q;
`ifdef EXEC_UNIT_MUL_LONG_EN
    assign bus.result_hi = res_hi_q;
`else
    assign bus.result_hi = '0;
`endif
endmodule

// File: tb/tb_exec_unit_mc.sv
// tb/tb_exec_unit_mc.sv - randomized self-checking bench for exec_unit_mc against an arithmetic model
module tb_exec_unit_mc;
    localparam int W = 32;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic [3:0] mdl_flags = 4'b0000;

    exec_unit_mc_if #(.WIDTH(W)) bus ();
    exec_unit_mc #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

    always #5 clk = ~clk;

    // Reference: plain 64-bit arithmetic over the operation definitions.
    function automatic void model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                  input logic sf, inout logic [3:0] f,
                                  output logic [31:0] lo, output logic [31:0] hi, output int lat);
        longint unsigned ux, uy, p;
        longint sx, sy, s;
        logic ovf;
        ux = x; uy = y; sx = $signed(x); sy = $signed(y);
        lo = 0; hi = 0; lat = 1; p = 0;
        case (o)
            3'd0: begin
                p = ux + uy; lo = p[31:0]; s = sx + sy;
                ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
                if (sf) f = {lo[31], lo == 0, p[32], ovf};
            end
            3'd1: begin
                lo = x - y; s = sx - sy;
                ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
                if (sf) f = {lo[31], lo == 0, ux >= uy, ovf};
            end
            3'd2: begin lo = x & y; if (sf) f = {lo[31], lo == 0, 2'b00}; end
            3'd3: begin lo = x | y; if (sf) f = {lo[31], lo == 0, 2'b00}; end
            3'd5: begin lo = y;     if (sf) f = {lo[31], lo == 0, 2'b00}; end
            3'd4: begin
                p = ux * uy; lat = W + 1; lo = p[31:0];
`ifdef EXEC_UNIT_MUL_LONG_EN
                hi = p[63:32];
                if (sf) f = {hi[31], p == 0, f[1:0]};
`else
                hi = 0;
                if (sf) f = {lo[31], lo == 0, f[1:0]};
`endif
            end
            default: lo = 0;
        endcase
    endfunction

    // Issue one op from IDLE and wait (bounded) for out_valid; out_ready stays low.
    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic sf, output int lat);
        bus.in_valid = 1'b1; bus.op = o; bus.a = x; bus.b = y; bus.set_flags = sf;
        bus.out_ready = 1'b0;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic retire();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.in_valid = 1'b0; bus.op = 3'd0; bus.a = '0; bus.b = '0;
        bus.set_flags = 1'b0; bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL reset_ctl: out_valid=%b busy=%b required 0 0", bus.out_valid, bus.busy);
        end
        checks++;
        if (bus.result_lo !== '0 || bus.result_hi !== '0 || bus.flags !== 4'b0000) begin
            errors++; $display("FAIL reset_data: lo=%h hi=%h flags=%b required 0 0 0000", bus.result_lo, bus.result_hi, bus.flags);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready: in_ready=%b required 1", bus.in_ready);
        end
        mdl_flags = 4'b0000;
    endtask

    task automatic test_flags_directed();
        int lat;
        logic [31:0] elo, ehi;
        int elat;
        model(3'd0, 32'h7FFFFFFF, 32'd1, 1'b1, mdl_flags, elo, ehi, elat);
        issue(3'd0, 32'h7FFFFFFF, 32'd1, 1'b1, lat);
        checks++;
        if (bus.result_lo !== 32'h80000000 || bus.flags !== 4'b1001 || lat != 1) begin
            errors++; $display("FAIL add_ovf: lo=%h flags=%b lat=%0d required 80000000 1001 1", bus.result_lo, bus.flags, lat);
        end
        retire();
        model(3'd1, 32'd5, 32'd5, 1'b1, mdl_flags, elo, ehi, elat);
        issue(3'd1, 32'd5, 32'd5, 1'b1, lat);
        checks++;
        if (bus.result_lo !== 32'd0 || bus.flags !== 4'b0110) begin
            errors++; $display("FAIL sub_zero: lo=%h flags=%b required 0 0110", bus.result_lo, bus.flags);
        end
        retire();
        model(3'd0, 32'd1, 32'd1, 1'b0, mdl_flags, elo, ehi, elat);
        issue(3'd0, 32'd1, 32'd1, 1'b0, lat);
        checks++;
        if (bus.result_lo !== 32'd2 || bus.flags !== 4'b0110) begin
            errors++; $display("FAIL add_noflags: lo=%h flags=%b required 2 0110", bus.result_lo, bus.flags);
        end
        retire();
    endtask

    task automatic test_mul();
        logic [31:0] elo, ehi;
        int elat, lat, bad;
        model(3'd4, 32'hFFFFFFFF, 32'd2, 1'b0, mdl_flags, elo, ehi, elat);
        bus.in_valid = 1'b1; bus.op = 3'd4; bus.a = 32'hFFFFFFFF; bus.b = 32'd2;
        bus.set_flags = 1'b0; bus.out_ready = 1'b0;
        @(posedge clk); #1;
        bus.op = 3'd0; bus.a = 32'd7; bus.b = 32'd9; bus.set_flags = 1'b1;
        bad = 0; lat = 1;
        while (!bus.out_valid && lat < 200) begin
            if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) bad++;
            @(posedge clk); #1;
            lat++;
        end
        bus.in_valid = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL mul_busy: %0d cycles without busy=1 in_ready=0, required 0", bad);
        end
        checks++;
        if (lat != elat) begin
            errors++; $display("FAIL mul_latency: %0d required %0d", lat, elat);
        end
        checks++;
        if (bus.result_lo !== elo || bus.result_hi !== ehi || bus.busy !== 1'b0) begin
            errors++; $display("FAIL mul_result: lo=%h hi=%h busy=%b required %h %h 0", bus.result_lo, bus.result_hi, bus.busy, elo, ehi);
        end
        retire();
    endtask

    task automatic test_back_to_back();
        logic [31:0] elo, ehi, x, y;
        int elat, lat;
        x = $urandom; y = $urandom;
        model(3'd3, x, y, 1'b0, mdl_flags, elo, ehi, elat);
        issue(3'd3, x, y, 1'b0, lat);
        bus.in_valid = 1'b1; bus.op = 3'd5; bus.b = ~elo; bus.set_flags = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (bus.out_valid !== 1'b1 || bus.result_lo !== elo || bus.in_ready !== 1'b0) begin
                errors++; $display("FAIL stall_%0d: valid=%b lo=%h in_ready=%b required 1 %h 0", i, bus.out_valid, bus.result_lo, bus.in_ready, elo);
            end
            @(posedge clk); #1;
        end
        bus.op = 3'd0; bus.a = 32'd2; bus.b = 32'd3; bus.set_flags = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL b2b_ready: in_ready=%b required 1", bus.in_ready);
        end
        model(3'd0, 32'd2, 32'd3, 1'b0, mdl_flags, elo, ehi, elat);
        @(posedge clk); #1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.result_lo !== 32'd5 || bus.flags !== mdl_flags) begin
            errors++; $display("FAIL b2b_result: valid=%b lo=%h flags=%b required 1 5 %b", bus.out_valid, bus.result_lo, bus.flags, mdl_flags);
        end
        retire();
    endtask

    task automatic test_reset_mid_mul();
        int lat, stale;
        bus.in_valid = 1'b1; bus.op = 3'd1; bus.a = 32'd0; bus.b = 32'd1; bus.set_flags = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        retire();
        bus.in_valid = 1'b1; bus.op = 3'd4; bus.a = $urandom; bus.b = $urandom; bus.set_flags = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        reset = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.flags !== 4'b0000 || bus.result_lo !== '0) begin
            errors++; $display("FAIL mid_mul_reset: valid=%b busy=%b flags=%b lo=%h required 0 0 0000 0", bus.out_valid, bus.busy, bus.flags, bus.result_lo);
        end
        mdl_flags = 4'b0000;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL post_reset_ready: in_ready=%b required 1", bus.in_ready);
        end
        stale = 0;
        bus.out_ready = 1'b1;
        for (lat = 0; lat < 40; lat++) begin
            @(posedge clk); #1;
            if (bus.out_valid !== 1'b0) stale++;
        end
        bus.out_ready = 1'b0;
        checks++;
        if (stale != 0) begin
            errors++; $display("FAIL stale_result: out_valid seen %0d cycles, required 0", stale);
        end
    endtask

    task automatic test_random();
        logic [31:0] edges [6];
        logic [31:0] x, y, elo, ehi;
        logic [2:0] o;
        logic sf;
        int elat, lat;
        edges[0] = 32'h0; edges[1] = 32'h1; edges[2] = 32'h7FFFFFFF;
        edges[3] = 32'h80000000; edges[4] = 32'hFFFFFFFF; edges[5] = 32'hFFFF0000;
        for (int i = 0; i < 40; i++) begin
            o  = 3'($urandom_range(0, 7));
            x  = ($urandom_range(0, 2) == 0) ? edges[$urandom_range(0, 5)] : $urandom;
            y  = ($urandom_range(0, 2) == 0) ? edges[$urandom_range(0, 5)] : $urandom;
            sf = 1'($urandom_range(0, 1));
            model(o, x, y, sf, mdl_flags, elo, ehi, elat);
            issue(o, x, y, sf, lat);
            checks++;
            if (bus.result_lo !== elo || bus.result_hi !== ehi || bus.flags !== mdl_flags || lat != elat) begin
                errors++;
                $display("FAIL rand_%0d op=%0d a=%h b=%h sf=%b: lo=%h hi=%h flags=%b lat=%0d required %h %h %b %0d",
                         i, o, x, y, sf, bus.result_lo, bus.result_hi, bus.flags, lat, elo, ehi, mdl_flags, elat);
            end
            retire();
        end
    endtask

    initial begin
        test_reset();
        test_flags_directed();
        test_mul();
        test_back_to_back();
        test_reset_mid_mul();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/exec_unit_mc.md
EXEC_UNIT_MC -- requirements
Module: exec_unit_mc

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width in bits (range 8..64).
REQ-002 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port in_valid  input  1  operation request valid.
REQ-005 SHALL have port in_ready  output  1  unit can accept an operation.
REQ-006 SHALL have port op  input  3  000 ADD, 001 SUB, 010 AND, 011 ORR, 100 MUL, 101 MOV (result=b); 110/111 reserved.
REQ-007 SHALL have port a  input  WIDTH  first operand (SrcA).
REQ-008 SHALL have port b  input  WIDTH  second operand (SrcB).
REQ-009 SHALL have port set_flags  input  1  update flags register on completion.
REQ-010 SHALL have port out_valid  output  1  result valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts result.
REQ-012 SHALL have port result_lo  output  WIDTH  result, low word.
REQ-013 SHALL have port result_hi  output  WIDTH  MUL product high word (see Configuration).
REQ-014 SHALL have port flags  output  4  registered NZCV, bit3=N ... bit0=V.
REQ-015 SHALL have port busy  output  1  high in MUL state.

Function
REQ-016 SHALL implement FSM states IDLE, MUL, DONE.
REQ-017 in_ready SHALL be 1 in IDLE, or in DONE when out_ready=1; 0 otherwise.
REQ-018 Accept = in_valid & in_ready; op, a, b, set_flags SHALL be captured at accept.
REQ-019 ADD/SUB/AND/ORR/MOV SHALL go to DONE with result registered: out_valid high 1 cycle after accept.
REQ-020 MUL SHALL go to MUL state, run WIDTH-step unsigned shift-add with step counter 0..WIDTH-1, enter DONE after WIDTH cycles: out_valid high WIDTH+1 cycles after accept.
REQ-021 In DONE, result_lo/result_hi/out_valid SHALL hold stable until out_ready=1.
REQ-022 DONE & out_ready & no accept SHALL go to IDLE; DONE & out_ready & accept SHALL take the new op directly (back-to-back, no bubble).
REQ-023 Inputs SHALL be ignored while in MUL or in DONE with out_ready=0.
REQ-024 Reserved op SHALL complete like a single-cycle op with result 0 and flags unchanged.
REQ-025 Flags SHALL update only on entry to DONE with captured set_flags=1: N=result msb, Z=(result==0).
REQ-026 ADD: C=carry out, V=signed overflow; SUB (a-b): C=no-borrow, V=signed overflow; AND/ORR/MOV: C=V=0; MUL: C,V preserved.
REQ-027 out_valid, busy SHALL never be high in IDLE; busy and out_valid SHALL be mutually exclusive.

Reset
REQ-028 reset=0 SHALL immediately force IDLE, out_valid=0, busy=0, result_lo=0, result_hi=0, flags=0000, counter=0.
REQ-029 reset mid-MUL or in DONE SHALL discard the operation; no result emitted after release.
REQ-030 in_ready SHALL be 1 the first cycle after reset release.

Configuration
REQ-031 Macro EXEC_UNIT_MUL_LONG_EN SHALL select long multiply.
REQ-032 Defined: result_hi = upper WIDTH bits of 2*WIDTH-bit product; MUL Z computed over both words, N = result_hi msb.
REQ-033 Undefined: result_hi tied 0, high-product accumulator omitted; MUL N/Z from result_lo only.

Verification (WIDTH=32)
REQ-034 ADD a=0x7FFFFFFF b=1 set_flags=1 -> result_lo 0x80000000, flags 1001, out_valid 1 cycle after accept.
REQ-035 SUB a=5 b=5 set_flags=1 -> result_lo 0, flags 0110; then ADD set_flags=0 -> flags stay 0110.
REQ-036 MUL a=0xFFFFFFFF b=2 -> result_lo 0xFFFFFFFE, result_hi 1 (0 without macro), out_valid 33 cycles after accept, in_ready=0 and busy=1 throughout.
REQ-037 ORR result with out_ready=0 for 3 cycles -> outputs stable, in_ready=0; out_ready=1 with in_valid=1 ADD 2+3 -> accepted same cycle, result 5 next cycle.
REQ-038 reset=0 at cycle 10 of MUL -> out_valid=0, flags 0000 immediately; after release in_ready=1, no stale result.
